// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared encodings for the logic gate unit.
//   OP_*    : 3-bit gate select encodings
//   MODE_*  : per-beat vs accumulate mode
//   state_t : frame FSM states
package logic_gate_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NAND  = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  localparam logic MODE_BEAT  = 1'b0;
  localparam logic MODE_ACCUM = 1'b1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

endpackage

// File: rtl/logic_gate_core.sv
// logic_gate_core: combinational bitwise gate.
//   A, B : operands (WIDTH)
//   OP   : gate select (logic_gate_pkg OP_* encodings)
//   Y    : OP applied per bit to A and B
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic [WIDTH-1:0] Y
);

  always_comb begin
    Y = A;
    case (OP)
      OP_AND:   Y = A & B;
      OP_OR:    Y = A | B;
      OP_NAND:  Y = ~(A & B);
      OP_NOR:   Y = ~(A | B);
      OP_XOR:   Y = A ^ B;
      OP_XNOR:  Y = ~(A ^ B);
      OP_NOTA:  Y = ~A;
      OP_PASSA: Y = A;
      default:  Y = A;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: bitwise gate with a single registered output and an
// optional OR-accumulate over FRAME accepted beats.
//   clk, rst           : rising-edge clock, async active-high reset
//   A, B, OP, MODE     : beat payload, qualified by in_valid
//   in_valid/in_ready  : input handshake (in_ready = !out_valid || out_ready)
//   Y/out_valid        : registered result, out_ready backpressure
//   Y_par              : XOR-reduction of Y, only with LOGIC_GATE_UNIT_PARITY_EN
// Optional feature macro: LOGIC_GATE_UNIT_PARITY_EN
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             MODE,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  ,
  output logic             Y_par
`endif
);

  localparam int CW = $clog2(FRAME + 1);
  // beat_cnt value seen while the last beat of a frame is being accepted
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [2:0]       op_lat_q, op_lat_d;
  logic             mode_lat_q, mode_lat_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;

  logic             in_frame;
  logic             accept;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] r;

  // Inside a frame the latched OP wins over whatever is on the OP pins.
  assign in_frame = (state_q == ACCUM) && (mode_lat_q == MODE_ACCUM);
  assign op_sel   = in_frame ? op_lat_q : OP;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  logic_gate_core #(.WIDTH(WIDTH)) u_core (
    .A  (A),
    .B  (B),
    .OP (op_sel),
    .Y  (r)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    op_lat_d    = op_lat_q;
    mode_lat_d  = mode_lat_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    // Drain first; a load below overrides this so there is no bubble.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (!in_frame) begin
        op_lat_d   = OP;
        mode_lat_d = MODE;
        if (MODE == MODE_ACCUM) begin
          acc_d      = r;
          beat_cnt_d = CW'(1);
          state_d    = ACCUM;
        end else begin
          y_d         = r;
          out_valid_d = 1'b1;
        end
      end else if (beat_cnt_q == LAST_CNT) begin
        y_d         = acc_q | r;
        out_valid_d = 1'b1;
        acc_d       = '0;
        beat_cnt_d  = '0;
        state_d     = IDLE;
      end else begin
        acc_d      = acc_q | r;
        beat_cnt_d = beat_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      op_lat_q    <= '0;
      mode_lat_q  <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      op_lat_q    <= op_lat_d;
      mode_lat_q  <= mode_lat_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = out_valid_q;

`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic y_par_q;
  // y_d holds y_q when nothing loads, so parity always tracks Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_par_q <= 1'b0;
    else     y_par_q <= ^y_d;
  end
  assign Y_par = y_par_q;
`endif

endmodule
